uart_rx: RTL



---
 rtl/uart_rx_if.sv | 11 +
 rtl/uart_rx.sv | 96 +++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Serial receive port bundle: the line input plus the decoded byte and status strobes.
interface uart_rx_if;
    logic       d;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    modport master (output d, input data, valid, frame_err, busy);
    modport slave  (input d, output data, valid, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop line synchronizer, mid-bit sampling FSM,
// one-cycle valid / frame_err strobes.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic     clk,
    input  logic     nrst,
    uart_rx_if.slave rx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

    state_t        state;
    logic          s1;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bitn;
    logic [7:0]    sh;
    logic [7:0]    data_r;
    logic          valid_r;
    logic          ferr_r;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state   <= IDLE;
            s1      <= 1'b1;
            rx_s    <= 1'b1;
            cnt     <= '0;
            bitn    <= '0;
            sh      <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
        end else begin
            s1      <= rx.d;
            rx_s    <= s1;
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= START;
                end
                // A start bit that is high again by mid-bit is treated as a glitch.
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt   <= '0;
                        bitn  <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        sh  <= {rx_s, sh[7:1]};
                        if (bitn == 3'd7) state <= STOP;
                        else              bitn  <= bitn + 3'd1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                // Returning to IDLE at mid-stop leaves half a bit to catch the next start edge.
                STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (rx_s) begin
                            data_r  <= sh;
                            valid_r <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            ferr_r <= 1'b1;
                            state  <= WAIT_HI;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                // Hold off through a break so a low line never starts a new frame.
                WAIT_HI: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rx.data      = data_r;
    assign rx.valid     = valid_r;
    assign rx.frame_err = ferr_r;
    assign rx.busy      = (state != IDLE);
endmodule
